call_stack_ctrl: RTL and testbench
==================================

Name: call_stack_ctrl

Overview:
Call/return controller for the 8-bit core. It sits directly upstream of the register file and drives its stack interface (rf_stack_push, rf_stack_pop, rf_stack_pointer) so that register context is saved on CALL and restored on RET. It also keeps the matching return addresses and issues a PC load to the fetch stage. It tracks stack depth and flags overflow and underflow.

Parameters:
PC_WIDTH, 6, width of PC values and of rf_stack_pointer
DEPTH, 8, maximum nested frames; legal range 1..(2**PC_WIDTH)-1
DW, $clog2(DEPTH+1), width of the depth counter (derived; not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cs_call  in  1  CALL request; sampled only while cs_ready=1
cs_ret  in  1  RET request; sampled only while cs_ready=1
cs_target  in  PC_WIDTH  CALL destination address
cs_ret_addr  in  PC_WIDTH  return address (PC+1 of the CALL)
cs_err_clr  in  1  clears the sticky error flags
cs_ready  out  1  high in IDLE; requests are accepted only when high
cs_pc_load  out  1  one-cycle pulse: fetch loads cs_pc_value
cs_pc_value  out  PC_WIDTH  new PC value
rf_stack_push  out  1  to reg_f: save context and clear registers
rf_stack_pop  out  1  to reg_f: restore context
rf_stack_pointer  out  PC_WIDTH  to reg_f: frame slot, zero-extended from the depth counter
cs_depth  out  DW  current frame count (sp)
cs_full  out  1  sp==DEPTH
cs_empty  out  1  sp==0
cs_overflow  out  1  sticky: CALL attempted while full
cs_underflow  out  1  sticky: RET attempted while empty

Behaviour:
- Slot convention: sp counts frames. Slot 0 is never used, so rf_stack_pointer is 0 only when no frame is addressed.
- A push writes slot sp+1. A pop reads slot sp.
- States: IDLE, PUSH, POP_ADDR, POP_COMMIT.
- Reset (async, any state): state=IDLE, sp=0, both sticky flags=0.
- Output values in reset/IDLE: cs_ready=1, cs_empty=1, cs_full=0. All other outputs are 0.
- Return-address memory contents are not reset.
- IDLE: rf_stack_pointer=sp.
  - cs_call with sp<DEPTH: latch cs_target and cs_ret_addr, go to PUSH.
  - cs_call with sp==DEPTH: set cs_overflow, stay in IDLE, no other effect.
  - cs_ret with sp>0: go to POP_ADDR.
  - cs_ret with sp==0: set cs_underflow, stay in IDLE, no other effect.
  - cs_call and cs_ret together: CALL has priority and RET is dropped silently.
- PUSH (1 cycle):
  - Outputs: rf_stack_push=1, rf_stack_pointer=sp+1, cs_pc_load=1, cs_pc_value=latched target.
  - Write latched return address to mem[sp+1].
  - At the end of the cycle sp<=sp+1, then IDLE.
  - CALL latency: pulses appear 1 cycle after acceptance.
- POP_ADDR (1 cycle):
  - rf_stack_pointer=sp, rf_stack_pop=0; presents the address to the synchronous-read stack RAM and to the return-address memory.
  - Go to POP_COMMIT.
- POP_COMMIT (1 cycle):
  - Outputs: rf_stack_pointer=sp (held), rf_stack_pop=1, cs_pc_load=1, cs_pc_value=mem[sp].
  - At the end of the cycle sp<=sp-1, then IDLE.
  - RET latency: pulses appear 2 cycles after acceptance.
- Busy states: cs_ready=0 and cs_call/cs_ret are ignored (not queued). Upstream stalls while cs_ready=0.
- rf_stack_push and rf_stack_pop are never high in the same cycle.
- cs_pc_load is exactly one cycle per successful CALL or RET.
- Sticky flags:
  - cs_err_clr clears both flags.
  - If a new error and cs_err_clr occur in the same cycle, the set wins.
- Reset mid-operation: any pending push, pop or PC load is abandoned, with no pulse after reset.
- Arithmetic: sp is unsigned DW bits. sp+1 and sp-1 are only evaluated when guarded, so sp never wraps.

Decomposition:
- Shared package cpu_pkg:
  - typedef enum cs_state_t {CS_IDLE, CS_PUSH, CS_POP_ADDR, CS_POP_COMMIT}
  - default PC_WIDTH and DEPTH constants, shared with reg_f
- One sub-module, cs_ret_mem:
  - (DEPTH+1) x PC_WIDTH storage
  - one synchronous write port, one synchronous-read port, no reset

Test Plan:
- Reset, then idle -> cs_ready=1, cs_empty=1, cs_depth=0, rf_stack_pointer=0, and every pulse output stays 0 for 10 cycles.
- cs_call with target=0x2A, ret_addr=0x05 -> next cycle: rf_stack_push=1, rf_stack_pointer=1, cs_pc_load=1, cs_pc_value=0x2A. Afterwards cs_depth=1.
- cs_ret at depth 1 -> cycle+1: pointer=1, pop=0. Cycle+2: rf_stack_pop=1, pointer=1, cs_pc_value=0x05. Afterwards cs_depth=0, cs_empty=1.
- 8 nested calls with ret_addr=0x10..0x17, then a 9th call -> push pointers 1..8, cs_full=1, 9th sets cs_overflow with no push. Then 8 rets -> cs_pc_value sequence 0x17..0x10.
- cs_ret when empty -> cs_underflow=1, no pop, no pc_load. cs_err_clr -> flag cleared. Call and ret asserted together at depth 0 -> call performed, no underflow.
- Assert rst while in POP_ADDR -> immediate IDLE, sp=0, no rf_stack_pop and no pc_load afterwards. A cs_call held during PUSH is not executed twice.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: call-stack FSM encoding and default PC/stack sizing,
// also consumed by reg_f so both sides agree on the frame-slot range.
package cpu_pkg;

  localparam int CS_PC_WIDTH = 6;
  localparam int CS_DEPTH    = 8;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_PUSH,
    CS_POP_ADDR,
    CS_POP_COMMIT
  } cs_state_t;

endpackage

// File: rtl/cs_ret_mem.sv
// Return-address store: one synchronous write port, one registered read port.
// Contents are deliberately not reset; slot 0 exists but is never written.
module cs_ret_mem #(
  parameter int W     = 6,
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/call_stack_ctrl.sv
// Call/return controller: drives the register-file context stack, keeps the
// matching return addresses and issues one-cycle PC loads to fetch.
module call_stack_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = CS_PC_WIDTH,
  parameter int DEPTH    = CS_DEPTH,
  localparam int DW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs_call,
  input  logic                cs_ret,
  input  logic [PC_WIDTH-1:0] cs_target,
  input  logic [PC_WIDTH-1:0] cs_ret_addr,
  input  logic                cs_err_clr,
  output logic                cs_ready,
  output logic                cs_pc_load,
  output logic [PC_WIDTH-1:0] cs_pc_value,
  output logic                rf_stack_push,
  output logic                rf_stack_pop,
  output logic [PC_WIDTH-1:0] rf_stack_pointer,
  output logic [DW-1:0]       cs_depth,
  output logic                cs_full,
  output logic                cs_empty,
  output logic                cs_overflow,
  output logic                cs_underflow
);

  // Handshake: a request is taken on a rising edge only while cs_ready=1;
  // requests seen while busy are dropped, so upstream must hold off until ready.

  cs_state_t           state_q, state_d;
  logic [DW-1:0]       sp_q, sp_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [PC_WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                mem_we;
  logic [DW-1:0]       sp_inc;
  logic [PC_WIDTH-1:0] mem_rdata;
  logic                full, empty;

  assign full   = (sp_q == DW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign sp_inc = sp_q + DW'(1);

  cs_ret_mem #(
    .W     (PC_WIDTH),
    .DEPTH (DEPTH),
    .AW    (DW)
  ) u_ret_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (sp_inc),
    .wdata (ret_addr_q),
    .raddr (sp_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d          = state_q;
    sp_d             = sp_q;
    target_d         = target_q;
    ret_addr_d       = ret_addr_q;
    overflow_d       = overflow_q;
    underflow_d      = underflow_q;
    mem_we           = 1'b0;
    cs_ready         = 1'b0;
    cs_pc_load       = 1'b0;
    cs_pc_value      = '0;
    rf_stack_push    = 1'b0;
    rf_stack_pop     = 1'b0;
    rf_stack_pointer = PC_WIDTH'(sp_q);

    // Clear first so an error detected this cycle overrides it.
    if (cs_err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    case (state_q)
      CS_IDLE: begin
        cs_ready = 1'b1;
        if (cs_call) begin
          if (!full) begin
            target_d   = cs_target;
            ret_addr_d = cs_ret_addr;
            state_d    = CS_PUSH;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (cs_ret) begin
          if (!empty) begin
            state_d = CS_POP_ADDR;
          end else begin
            underflow_d = 1'b1;
          end
        end
      end
      CS_PUSH: begin
        rf_stack_push    = 1'b1;
        rf_stack_pointer = PC_WIDTH'(sp_inc);
        cs_pc_load       = 1'b1;
        cs_pc_value      = target_q;
        mem_we           = 1'b1;
        sp_d             = sp_inc;
        state_d          = CS_IDLE;
      end
      CS_POP_ADDR: begin
        state_d = CS_POP_COMMIT;
      end
      CS_POP_COMMIT: begin
        rf_stack_pop = 1'b1;
        cs_pc_load   = 1'b1;
        cs_pc_value  = mem_rdata;
        sp_d         = sp_q - DW'(1);
        state_d      = CS_IDLE;
      end
      default: begin
        state_d = CS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CS_IDLE;
      sp_q        <= '0;
      target_q    <= '0;
      ret_addr_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      target_q    <= target_d;
      ret_addr_q  <= ret_addr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign cs_depth     = sp_q;
  assign cs_full      = full;
  assign cs_empty     = empty;
  assign cs_overflow  = overflow_q;
  assign cs_underflow = underflow_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: linear steps, hand-computed expectations.
module tb_call_stack_ctrl;

  localparam int PW = 6;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs_call, cs_ret, cs_err_clr;
  logic [PW-1:0] cs_target, cs_ret_addr;
  logic          cs_ready, cs_pc_load, rf_stack_push, rf_stack_pop;
  logic [PW-1:0] cs_pc_value, rf_stack_pointer;
  logic [DW-1:0] cs_depth;
  logic          cs_full, cs_empty, cs_overflow, cs_underflow;

  int n_cmp = 0;
  int n_err = 0;

  call_stack_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cs_call          (cs_call),
    .cs_ret           (cs_ret),
    .cs_target        (cs_target),
    .cs_ret_addr      (cs_ret_addr),
    .cs_err_clr       (cs_err_clr),
    .cs_ready         (cs_ready),
    .cs_pc_load       (cs_pc_load),
    .cs_pc_value      (cs_pc_value),
    .rf_stack_push    (rf_stack_push),
    .rf_stack_pop     (rf_stack_pop),
    .rf_stack_pointer (rf_stack_pointer),
    .cs_depth         (cs_depth),
    .cs_full          (cs_full),
    .cs_empty         (cs_empty),
    .cs_overflow      (cs_overflow),
    .cs_underflow     (cs_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int depth);
    chk({tag, " ready"}, cs_ready, 1);
    chk({tag, " push"}, rf_stack_push, 0);
    chk({tag, " pop"}, rf_stack_pop, 0);
    chk({tag, " load"}, cs_pc_load, 0);
    chk({tag, " pcval"}, cs_pc_value, 0);
    chk({tag, " depth"}, cs_depth, depth);
    chk({tag, " ptr"}, rf_stack_pointer, depth);
  endtask

  initial begin
    rst = 1'b1; cs_call = 0; cs_ret = 0; cs_err_clr = 0;
    cs_target = '0; cs_ret_addr = '0;
    repeat (2) tick();
    chk("rst empty", cs_empty, 1);
    chk("rst full", cs_full, 0);
    chk("rst ovf", cs_overflow, 0);
    chk("rst unf", cs_underflow, 0);
    chk_idle("rst", 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("idle", 0);
      chk("idle empty", cs_empty, 1);
    end

    // Single call / return
    cs_call = 1; cs_target = 6'h2A; cs_ret_addr = 6'h05;
    tick();
    cs_call = 0;
    chk("call1 push", rf_stack_push, 1);
    chk("call1 ptr", rf_stack_pointer, 1);
    chk("call1 load", cs_pc_load, 1);
    chk("call1 pcval", cs_pc_value, 6'h2A);
    chk("call1 ready", cs_ready, 0);
    chk("call1 pop", rf_stack_pop, 0);
    tick();
    chk_idle("after call1", 1);
    chk("after call1 empty", cs_empty, 0);

    cs_ret = 1;
    tick();
    cs_ret = 0;
    chk("ret1a ptr", rf_stack_pointer, 1);
    chk("ret1a pop", rf_stack_pop, 0);
    chk("ret1a load", cs_pc_load, 0);
    chk("ret1a ready", cs_ready, 0);
    tick();
    chk("ret1b pop", rf_stack_pop, 1);
    chk("ret1b ptr", rf_stack_pointer, 1);
    chk("ret1b load", cs_pc_load, 1);
    chk("ret1b pcval", cs_pc_value, 6'h05);
    chk("ret1b push", rf_stack_push, 0);
    tick();
    chk_idle("after ret1", 0);
    chk("after ret1 empty", cs_empty, 1);

    // Eight nested calls, then overflow
    for (int i = 0; i < 8; i++) begin
      cs_call = 1; cs_target = PW'(6'h20 + i); cs_ret_addr = PW'(6'h10 + i);
      tick();
      cs_call = 0;
      chk("nest push", rf_stack_push, 1);
      chk("nest ptr", rf_stack_pointer, i + 1);
      chk("nest pcval", cs_pc_value, 6'h20 + i);
      tick();
      chk("nest depth", cs_depth, i + 1);
    end
    chk("full", cs_full, 1);
    cs_call = 1; cs_target = 6'h3F; cs_ret_addr = 6'h3E;
    tick();
    cs_call = 0;
    chk("ovf flag", cs_overflow, 1);
    chk_idle("ovf", 8);
    tick();
    chk_idle("ovf hold", 8);
    chk("ovf sticky", cs_overflow, 1);

    for (int i = 0; i < 8; i++) begin
      cs_ret = 1;
      tick();
      cs_ret = 0;
      chk("unnest a pop", rf_stack_pop, 0);
      tick();
      chk("unnest pop", rf_stack_pop, 1);
      chk("unnest ptr", rf_stack_pointer, 8 - i);
      chk("unnest pcval", cs_pc_value, 6'h17 - i);
      tick();
      chk("unnest depth", cs_depth, 7 - i);
    end
    chk("unnest empty", cs_empty, 1);

    // Sticky flags
    cs_err_clr = 1;
    tick();
    cs_err_clr = 0;
    chk("clr ovf", cs_overflow, 0);
    cs_ret = 1;
    tick();
    cs_ret = 0;
    chk("unf flag", cs_underflow, 1);
    chk_idle("unf", 0);
    cs_err_clr = 1;
    tick();
    chk("clr unf", cs_underflow, 0);
    cs_ret = 1;
    tick();
    cs_ret = 0; cs_err_clr = 0;
    chk("set wins", cs_underflow, 1);
    cs_err_clr = 1;
    tick();
    cs_err_clr = 0;
    chk("clr again", cs_underflow, 0);

    // CALL has priority over RET at depth 0
    cs_call = 1; cs_ret = 1; cs_target = 6'h11; cs_ret_addr = 6'h22;
    tick();
    cs_call = 0; cs_ret = 0;
    chk("both push", rf_stack_push, 1);
    chk("both pcval", cs_pc_value, 6'h11);
    chk("both unf", cs_underflow, 0);
    tick();
    chk_idle("both after", 1);
    chk("both unf2", cs_underflow, 0);

    // Reset while in POP_ADDR
    cs_ret = 1;
    tick();
    cs_ret = 0;
    chk("pre-rst ready", cs_ready, 0);
    rst = 1;
    #1;
    chk_idle("mid rst", 0);
    chk("mid rst empty", cs_empty, 1);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("post rst", 0);
    end

    // Call held across PUSH executes once
    cs_call = 1; cs_target = 6'h33; cs_ret_addr = 6'h01;
    tick();
    chk("held push", rf_stack_push, 1);
    tick();
    cs_call = 0;
    chk_idle("held idle", 1);
    tick();
    chk_idle("held once", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
